// File: rtl/scalar_memory_pkg.sv
// scalar_memory_pkg: shared widths, flag bit positions and FSM states for the scalar memory stage
package scalar_mem_pkg;
   localparam int DATA_W = 36;
   localparam int RD_W   = 5;
   localparam int FLAG_Z = 0;
   localparam int FLAG_S = 1;
   localparam int FLAG_V = 2;
   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
endpackage

// File: rtl/scalar_memory_if.sv
// scalar_memory_if: request/ready/response bus between the scalar memory stage and the data cache
interface scalar_memory_if;
   import scalar_mem_pkg::*;
   logic              dc_req;
   logic              dc_we;
   logic [DATA_W-1:0] dc_addr;
   logic [DATA_W-1:0] dc_wdata;
   logic              dc_ready;
   logic              dc_rvalid;
   logic [DATA_W-1:0] dc_rdata;
   modport master (output dc_req, dc_we, dc_addr, dc_wdata, input dc_ready, dc_rvalid, dc_rdata);
   modport slave  (input dc_req, dc_we, dc_addr, dc_wdata, output dc_ready, dc_rvalid, dc_rdata);
endinterface

// File: rtl/scalar_memory.sv
// scalar_memory: load/store stage with cache handshake, registered writeback bundle and flag register
module scalar_memory
   import scalar_mem_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [DATA_W-1:0]    alu_result,
   input  logic [DATA_W-1:0]    store_data,
   input  logic                 mem_read,
   input  logic                 mem_write,
   input  logic                 reg_write,
   input  logic                 flag_write,
   input  logic [RD_W-1:0]      rd,
   input  logic                 zero_in,
   input  logic                 sign_in,
   input  logic                 overflow_in,
   output logic                 stall,
   scalar_memory_if.master      dc,
   output logic                 wb_valid,
   output logic                 wb_reg_write,
   output logic [RD_W-1:0]      wb_rd,
   output logic [DATA_W-1:0]    wb_data,
   output logic [2:0]           flags
);
   state_t            state_q, state_d;
   logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d, wb_data_q, wb_data_d;
   logic              we_q, we_d, regw_q, regw_d, wb_valid_q, wb_valid_d, wb_regw_q, wb_regw_d;
   logic [RD_W-1:0]   rd_q, rd_d, wb_rd_q, wb_rd_d;
   logic [2:0]        flags_q, flags_d;
   logic              accept;

   assign accept       = in_valid && state_q == IDLE;
   assign stall        = state_q != IDLE;
   assign dc.dc_req    = state_q == REQ;
   assign dc.dc_we     = we_q;
   assign dc.dc_addr   = addr_q;
   assign dc.dc_wdata  = wdata_q;
   assign wb_valid     = wb_valid_q;
   assign wb_reg_write = wb_regw_q;
   assign wb_rd        = wb_rd_q;
   assign wb_data      = wb_data_q;
   assign flags        = flags_q;

   // next state, access capture, writeback bundle and flag update
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      rd_d       = rd_q;
      regw_d     = regw_q;
      wb_valid_d = 1'b0;
      wb_regw_d  = wb_regw_q;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      flags_d    = flags_q;
      if (accept && flag_write) begin
         flags_d[FLAG_Z] = zero_in;
         flags_d[FLAG_S] = sign_in;
         flags_d[FLAG_V] = overflow_in;
      end
      case (state_q)
         IDLE: if (accept) begin
            if (mem_read || mem_write) begin
               state_d = REQ;
               addr_d  = alu_result;
               wdata_d = store_data;
               we_d    = mem_write && !mem_read;
               rd_d    = rd;
               regw_d  = reg_write;
            end else begin
               wb_valid_d = 1'b1;
               wb_data_d  = alu_result;
               wb_rd_d    = rd;
               wb_regw_d  = reg_write;
            end
         end
         REQ: if (dc.dc_ready) begin
            if (we_q) begin
               state_d    = IDLE;
               wb_valid_d = 1'b1;
               wb_rd_d    = rd_q;
               wb_regw_d  = 1'b0;
            end else if (dc.dc_rvalid) begin
               state_d    = IDLE;
               wb_valid_d = 1'b1;
               wb_data_d  = dc.dc_rdata;
               wb_rd_d    = rd_q;
               wb_regw_d  = regw_q;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: if (dc.dc_rvalid) begin
            state_d    = IDLE;
            wb_valid_d = 1'b1;
            wb_data_d  = dc.dc_rdata;
            wb_rd_d    = rd_q;
            wb_regw_d  = regw_q;
         end
         default: state_d = IDLE;
      endcase
   end

   // state and data registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         rd_q       <= '0;
         regw_q     <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_regw_q  <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         flags_q    <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         rd_q       <= rd_d;
         regw_q     <= regw_d;
         wb_valid_q <= wb_valid_d;
         wb_regw_q  <= wb_regw_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         flags_q    <= flags_d;
      end
   end
endmodule
